tach_pulse_gen: RTL and testbench

Generates a tachometer/encoder pulse train on `data` that corresponds to a commanded shaft speed in RPM. It is the stimulus-side counterpart of the RPM frequency counter. It converts `rpm_cmd` into a pulse period in `clk` cycles using an iterative divider, then emits a roughly 50 % duty square wave at `PPR` pulses per revolution. It is used for motor-emulation benches and for loopback self-test of the speed-measurement path.

---
 rtl/tach_pulse_gen_pkg.sv | 20 ++
 rtl/tach_pulse_gen_seq_divider.sv | 68 ++++++
 rtl/tach_pulse_gen.sv | 146 ++++++++++++++
 tb/tb_tach_pulse_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tach_pulse_gen_pkg.sv
// Shared widths, FSM encoding and the clock-dependent ticks-per-minute constant
// for the tachometer pulse generator.
package tach_pkg;

  localparam int unsigned PERIOD_W = 40;
  localparam int unsigned DIV_W    = 48;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    RUN
  } tach_state_t;

  function automatic logic [PERIOD_W-1:0] ticks_per_min(input int unsigned clk_period_ns);
    logic [63:0] w_ticks;
    w_ticks = 64'd60_000_000_000 / 64'(clk_period_ns);
    return w_ticks[PERIOD_W-1:0];
  endfunction

endpackage

// File: rtl/tach_pulse_gen_seq_divider.sv
// Restoring divider, one quotient bit per clock. The first bit is resolved in the
// start cycle, so the quotient is complete DVD_W-1 clocks after start.
module seq_divider #(
  parameter int unsigned DVD_W = 40,
  parameter int unsigned DVS_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_W);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DVS_W-1:0] r_rem;
  logic [DVD_W-1:0] r_quo;
  logic [DVS_W-1:0] r_dvs;

  logic [DVS_W-1:0] w_src_rem;
  logic [DVD_W-1:0] w_src_quo;
  logic [DVS_W-1:0] w_src_dvs;
  logic [DVS_W:0]   w_trial;
  logic             w_ge;
  logic [DVS_W-1:0] w_nrem;
  logic [DVD_W-1:0] w_nquo;

  // The shifted-out dividend bits and the new quotient bits share r_quo.
  always_comb begin
    w_src_rem = start ? '0       : r_rem;
    w_src_quo = start ? dividend : r_quo;
    w_src_dvs = start ? divisor  : r_dvs;
    w_trial   = {w_src_rem, w_src_quo[DVD_W-1]};
    w_ge      = (w_trial >= {1'b0, w_src_dvs});
    w_nrem    = w_ge ? (w_trial[DVS_W-1:0] - w_src_dvs) : w_trial[DVS_W-1:0];
    w_nquo    = {w_src_quo[DVD_W-2:0], w_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(DVD_W - 1);
      r_rem  <= w_nrem;
      r_quo  <= w_nquo;
      r_dvs  <= divisor;
    end else if (r_busy && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - 1'b1;
      r_rem  <= w_nrem;
      r_quo  <= w_nquo;
    end else if (r_busy) begin
      r_busy <= 1'b0;
    end
  end

  assign done     = r_busy && (r_cnt == '0);
  assign quotient = r_quo;

endmodule

// File: rtl/tach_pulse_gen.sv
// Tachometer pulse-train generator: converts an RPM command into a clock-count
// period and emits a glitch-free ~50% square wave at PPR pulses per revolution.
module tach_pulse_gen
  import tach_pkg::*;
#(
  parameter int CLK_PERIOD = 10,
  parameter int PPR        = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         rpm_cmd,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  output logic                data,
  output logic [PERIOD_W-1:0] period_clks,
  output logic                running
);

  localparam logic [PERIOD_W-1:0] TICKS_PER_MIN = ticks_per_min(CLK_PERIOD);
  localparam logic [DIV_W-1:0]    PPR_W         = DIV_W'(PPR);

  tach_state_t r_state, w_state_nxt;

  logic                r_data;
  logic                r_running;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_phase;
  logic [PERIOD_W-1:0] r_pend;
  logic                r_pend_valid;
  logic                r_stop;

  logic                w_ready;
  logic                w_go;
  logic                w_stop_cmd;
  logic [DIV_W-1:0]    w_divisor;
  logic                w_div_done;
  logic [PERIOD_W-1:0] w_quotient;
  logic [PERIOD_W-1:0] w_q;
  logic                w_boundary;
  logic                w_stop_now;
  logic                w_pend_avail;
  logic [PERIOD_W-1:0] w_pend_val;

  assign w_ready    = (r_state == IDLE) || (r_state == RUN);
  assign w_go       = cmd_valid && w_ready && (rpm_cmd != '0);
  assign w_stop_cmd = cmd_valid && w_ready && (rpm_cmd == '0) && (r_state == RUN);
  assign w_divisor  = DIV_W'(rpm_cmd) * PPR_W;

  seq_divider #(
    .DVD_W (PERIOD_W),
    .DVS_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_go),
    .dividend (TICKS_PER_MIN),
    .divisor  (w_divisor),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  assign w_q = (w_quotient < PERIOD_W'(2)) ? PERIOD_W'(2) : w_quotient;

  // Boundary is the last cycle of a low phase; a result finishing on that very
  // cycle is forwarded so it is not held back a whole period.
  assign w_boundary   = r_running && !r_data && (r_phase == PERIOD_W'(1));
  assign w_stop_now   = w_boundary && r_stop && !w_go;
  assign w_pend_avail = r_pend_valid || w_div_done;
  assign w_pend_val   = w_div_done ? w_q : r_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_go) w_state_nxt = DIVIDE;
      DIVIDE:  if (w_div_done) w_state_nxt = RUN;
      RUN: begin
        if (w_go)            w_state_nxt = DIVIDE;
        else if (w_stop_now) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= 1'b0;
      r_running    <= 1'b0;
      r_period     <= '0;
      r_phase      <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_stop       <= 1'b0;
    end else begin
      if (w_go)            r_stop <= 1'b0;
      else if (w_stop_cmd) r_stop <= 1'b1;

      if (w_stop_now) begin
        r_running    <= 1'b0;
        r_data       <= 1'b0;
        r_period     <= '0;
        r_phase      <= '0;
        r_pend_valid <= 1'b0;
        r_stop       <= 1'b0;
      end else if (w_div_done && !r_running) begin
        r_running    <= 1'b1;
        r_data       <= 1'b1;
        r_period     <= w_q;
        r_phase      <= w_q >> 1;
        r_pend_valid <= 1'b0;
      end else if (w_boundary) begin
        r_data <= 1'b1;
        if (w_pend_avail) begin
          r_period     <= w_pend_val;
          r_phase      <= w_pend_val >> 1;
          r_pend_valid <= 1'b0;
        end else begin
          r_phase <= r_period >> 1;
        end
      end else begin
        if (w_div_done) begin
          r_pend       <= w_q;
          r_pend_valid <= 1'b1;
        end
        if (r_running) begin
          if (r_data && (r_phase == PERIOD_W'(1))) begin
            r_data  <= 1'b0;
            r_phase <= r_period - (r_period >> 1);
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready   = w_ready;
  assign data        = r_data;
  assign period_clks = r_period;
  assign running     = r_running;

endmodule

// File: tb/tb_tach_pulse_gen.sv
// Directed self-checking bench for tach_pulse_gen (CLK_PERIOD=10, PPR=20);
// RPM values are chosen so periods stay in the hundreds-to-thousands of clocks.
module tb_tach_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rpm_cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        data;
  logic [39:0] period_clks;
  logic        running;

  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  always #5 clk = ~clk;

  tach_pulse_gen #(
    .CLK_PERIOD (10),
    .PPR        (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rpm_cmd     (rpm_cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .data        (data),
    .period_clks (period_clks),
    .running     (running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; rpm_cmd = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic [31:0] rpm);
    rpm_cmd = rpm; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, input int unsigned limit, output int unsigned at);
    int unsigned n = 0;
    while (data !== lvl && n < limit) begin
      tick(); n++;
    end
    at = cyc;
  endtask

  task automatic measure(input logic lvl, output int unsigned len);
    len = 0;
    while (data === lvl && len < 5000) begin
      len++; tick();
    end
  endtask

  task automatic count_not_ready(output int unsigned len);
    len = 0;
    while (cmd_ready !== 1'b1 && len < 200) begin
      len++; tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rpm_cmd = '0;
    tick(); tick();
    n_checks++; if (data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %0b expected 0", data); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
    n_checks++; if (period_clks !== 40'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_clks); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int unsigned early, len;
    do_reset();
    send(32'd300_000);
    early = 0;
    for (int i = 0; i < 40; i++) begin
      if (data !== 1'b0) early++;
      tick();
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL basic_early_high: got %0d high samples expected 0", early); end
    n_checks++; if (data !== 1'b1) begin n_fail++; $display("FAIL basic_rise_a41: got %0b expected 1", data); end
    n_checks++; if (period_clks !== 40'd1000) begin n_fail++; $display("FAIL basic_period: got %0d expected 1000", period_clks); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %0b expected 1", running); end
    measure(1'b1, len);
    n_checks++; if (len !== 500) begin n_fail++; $display("FAIL basic_high: got %0d expected 500", len); end
    measure(1'b0, len);
    n_checks++; if (len !== 500) begin n_fail++; $display("FAIL basic_low: got %0d expected 500", len); end
    measure(1'b1, len);
    n_checks++; if (len !== 500) begin n_fail++; $display("FAIL basic_high2: got %0d expected 500", len); end
  endtask

  task automatic test_async_reset();
    int unsigned t, highs;
    do_reset();
    send(32'd300_000);
    wait_level(1'b1, 100, t);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (data !== 1'b0) begin n_fail++; $display("FAIL async_rst_data: got %0b expected 0", data); end
    n_checks++; if (period_clks !== 40'd0) begin n_fail++; $display("FAIL async_rst_period: got %0d expected 0", period_clks); end
    tick();
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      if (data !== 1'b0 || running !== 1'b0) highs++;
      tick();
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL async_rst_no_pulse: got %0d active samples expected 0", highs); end
  endtask

  task automatic test_fast();
    int unsigned t, len;
    do_reset();
    send(32'd100_000_000);
    wait_level(1'b1, 100, t);
    n_checks++; if (period_clks !== 40'd3) begin n_fail++; $display("FAIL fast_period: got %0d expected 3", period_clks); end
    measure(1'b1, len);
    n_checks++; if (len !== 1) begin n_fail++; $display("FAIL fast_high: got %0d expected 1", len); end
    measure(1'b0, len);
    n_checks++; if (len !== 2) begin n_fail++; $display("FAIL fast_low: got %0d expected 2", len); end
    do_reset();
    send(32'hFFFF_FFFF);
    wait_level(1'b1, 100, t);
    n_checks++; if (period_clks !== 40'd2) begin n_fail++; $display("FAIL clamp_period: got %0d expected 2", period_clks); end
    measure(1'b1, len);
    n_checks++; if (len !== 1) begin n_fail++; $display("FAIL clamp_high: got %0d expected 1", len); end
    measure(1'b0, len);
    n_checks++; if (len !== 1) begin n_fail++; $display("FAIL clamp_low: got %0d expected 1", len); end
  endtask

  task automatic test_retarget();
    int unsigned r, f, r2, len;
    do_reset();
    send(32'd300_000);
    wait_level(1'b1, 100, r);
    for (int i = 0; i < 100; i++) tick();
    send(32'd600_000);
    count_not_ready(len);
    n_checks++; if (len !== 40) begin n_fail++; $display("FAIL retarget_ready_low: got %0d expected 40", len); end
    wait_level(1'b0, 2000, f);
    n_checks++; if (f - r !== 500) begin n_fail++; $display("FAIL retarget_old_high: got %0d expected 500", f - r); end
    n_checks++; if (period_clks !== 40'd1000) begin n_fail++; $display("FAIL retarget_old_period: got %0d expected 1000", period_clks); end
    wait_level(1'b1, 2000, r2);
    n_checks++; if (r2 - f !== 500) begin n_fail++; $display("FAIL retarget_old_low: got %0d expected 500", r2 - f); end
    n_checks++; if (period_clks !== 40'd500) begin n_fail++; $display("FAIL retarget_new_period: got %0d expected 500", period_clks); end
    measure(1'b1, len);
    n_checks++; if (len !== 250) begin n_fail++; $display("FAIL retarget_new_high: got %0d expected 250", len); end
    measure(1'b0, len);
    n_checks++; if (len !== 250) begin n_fail++; $display("FAIL retarget_new_low: got %0d expected 250", len); end
  endtask

  task automatic test_stop();
    int unsigned r, f, n, bad;
    do_reset();
    send(32'd600_000);
    wait_level(1'b1, 100, r);
    for (int i = 0; i < 10; i++) tick();
    send(32'd0);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL stop_ready: got %0b expected 1", cmd_ready); end
    wait_level(1'b0, 1000, f);
    n_checks++; if (f - r !== 250) begin n_fail++; $display("FAIL stop_high_intact: got %0d expected 250", f - r); end
    n = 0; bad = 0;
    while (running === 1'b1 && n < 2000) begin
      if (data !== 1'b0) bad++;
      n++; tick();
    end
    n_checks++; if (n !== 250 || bad !== 0) begin n_fail++; $display("FAIL stop_low_intact: got %0d low cycles (%0d high) expected 250", n, bad); end
    n_checks++; if (period_clks !== 40'd0) begin n_fail++; $display("FAIL stop_period: got %0d expected 0", period_clks); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (data !== 1'b0 || running !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_stays_idle: got %0d active samples expected 0", bad); end

    do_reset();
    send(32'd600_000);
    wait_level(1'b1, 100, r);
    for (int i = 0; i < 10; i++) tick();
    send(32'd0);
    for (int i = 0; i < 10; i++) tick();
    send(32'd300_000);
    wait_level(1'b0, 1000, f);
    wait_level(1'b1, 1000, n);
    n_checks++; if (n - r !== 500) begin n_fail++; $display("FAIL cancel_boundary: got %0d expected 500", n - r); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL cancel_running: got %0b expected 1", running); end
    n_checks++; if (period_clks !== 40'd1000) begin n_fail++; $display("FAIL cancel_period: got %0d expected 1000", period_clks); end
  endtask

  task automatic test_hold_valid();
    int unsigned r, n, t, len;
    do_reset();
    send(32'd300_000);
    wait_level(1'b1, 100, r);
    rpm_cmd = 32'd600_000; cmd_valid = 1'b1;
    tick();
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      if (n == 10) rpm_cmd = 32'd3_000_000;
      n++; tick();
    end
    n_checks++; if (n !== 40) begin n_fail++; $display("FAIL hold_ready_low1: got %0d expected 40", n); end
    tick();
    cmd_valid = 1'b0;
    count_not_ready(len);
    n_checks++; if (len !== 40) begin n_fail++; $display("FAIL hold_ready_low2: got %0d expected 40", len); end
    n_checks++; if (period_clks !== 40'd1000) begin n_fail++; $display("FAIL hold_old_period: got %0d expected 1000", period_clks); end
    wait_level(1'b0, 2000, t);
    wait_level(1'b1, 2000, t);
    n_checks++; if (t - r !== 1000) begin n_fail++; $display("FAIL hold_boundary: got %0d expected 1000", t - r); end
    n_checks++; if (period_clks !== 40'd100) begin n_fail++; $display("FAIL hold_last_wins: got %0d expected 100", period_clks); end
    measure(1'b1, len);
    n_checks++; if (len !== 50) begin n_fail++; $display("FAIL hold_high: got %0d expected 50", len); end
    measure(1'b0, len);
    n_checks++; if (len !== 50) begin n_fail++; $display("FAIL hold_low: got %0d expected 50", len); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1; cmd_valid = 1'b0; rpm_cmd = '0;
    test_reset();
    test_basic();
    test_async_reset();
    test_fast();
    test_retarget();
    test_stop();
    test_hold_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
